// File: rtl/mac_tb_pkg.sv
// rtl/mac_tb_pkg.sv - shared types and constants for the MAC transmit scheduler
package mac_tb_pkg;

    localparam int PAYLOAD_MAX_DEFAULT = 1500;

    localparam logic [7:0] MODE_NORMAL = 8'd0;
    localparam logic [7:0] MODE_FIXED  = 8'd1;
    localparam logic [7:0] MODE_NOPAD  = 8'd2;
    localparam logic [7:0] MODE_PRBS8  = 8'd3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LAUNCH,
        ST_START,
        ST_WAIT_TX,
        ST_IN_TX,
        ST_GAP,
        ST_FINISH,
        ST_ERR
    } sched_state_t;

    function automatic logic [15:0] clamp_len(input logic [15:0] len, input logic [15:0] max_len);
        return (len > max_len) ? max_len : len;
    endfunction

endpackage

// File: rtl/sched_len_sweep.sv
// rtl/sched_len_sweep.sv - next payload length for the sweep, with clamp and wrap
module sched_len_sweep
    import mac_tb_pkg::*;
#(
    parameter int PAYLOAD_MAX_SIZE = PAYLOAD_MAX_DEFAULT
) (
    input  logic [15:0] cur_len,
    input  logic [15:0] len_min,
    input  logic [15:0] len_max,
    input  logic [15:0] len_step,
    output logic [15:0] next_len
);

    localparam logic [15:0] LEN_CAP = 16'(PAYLOAD_MAX_SIZE);

    logic [16:0] sum;

    // 17-bit sum so a large step cannot alias back below the bounds
    assign sum = {1'b0, cur_len} + {1'b0, len_step};

    always_comb begin
        next_len = len_min;
        if (len_min > len_max) begin
            next_len = clamp_len(len_min, LEN_CAP);
        end else if ((sum > {1'b0, len_max}) || (sum > {1'b0, LEN_CAP})) begin
            next_len = len_min;
        end else begin
            next_len = sum[15:0];
        end
    end

endmodule

// File: rtl/mac_tx_scheduler.sv
// rtl/mac_tx_scheduler.sv - burst sequencer driving start/length into mac_mii_top
module mac_tx_scheduler
    import mac_tb_pkg::*;
#(
    parameter int PAYLOAD_MAX_SIZE   = PAYLOAD_MAX_DEFAULT,
    parameter int START_PULSE_CYCLES = 2,
    parameter int GAP_WIDTH          = 16,
    parameter int WDOG_CYCLES        = 4096
) (
    input  logic                 clk,
    input  logic                 i_rst,
    input  logic                 i_go,
    input  logic                 i_abort,
    input  logic [15:0]          i_num_frames,
    input  logic [15:0]          i_len_min,
    input  logic [15:0]          i_len_max,
    input  logic [15:0]          i_len_step,
    input  logic [7:0]           i_mode,
    input  logic [GAP_WIDTH-1:0] i_gap_cycles,
    input  logic                 i_tx_valid,
    output logic                 o_start,
    output logic [15:0]          o_payload_length,
    output logic [7:0]           o_mode,
    output logic                 o_prbs_rst_n,
    output logic                 o_busy,
    output logic                 o_done,
    output logic [15:0]          o_frames_sent,
    output logic                 o_wdog_err
);

    localparam int PULSE_W = $clog2(START_PULSE_CYCLES) + 1;
    localparam int WD_W    = $clog2(WDOG_CYCLES) + 1;
    localparam logic [PULSE_W-1:0] PULSE_LAST = PULSE_W'(START_PULSE_CYCLES - 1);
    localparam logic [WD_W-1:0]    WDOG_LAST  = WD_W'(WDOG_CYCLES - 1);
    localparam logic [15:0]        LEN_CAP    = 16'(PAYLOAD_MAX_SIZE);

    sched_state_t         state;
    logic [15:0]          num_frames;
    logic [15:0]          len_min;
    logic [15:0]          len_max;
    logic [15:0]          len_step;
    logic [15:0]          cur_len;
    logic [15:0]          next_len;
    logic [15:0]          frames_inc;
    logic [GAP_WIDTH-1:0] gap_cycles;
    logic [GAP_WIDTH-1:0] gap_cnt;
    logic [PULSE_W-1:0]   pulse_cnt;
    logic [WD_W-1:0]      wdog_cnt;
    logic                 abort_pend;
    logic                 abort_now;
    logic                 stop_at_fall;
    logic                 stop_at_gap;

    sched_len_sweep #(
        .PAYLOAD_MAX_SIZE(PAYLOAD_MAX_SIZE)
    ) u_len_sweep (
        .cur_len (cur_len),
        .len_min (len_min),
        .len_max (len_max),
        .len_step(len_step),
        .next_len(next_len)
    );

    assign abort_now  = abort_pend | i_abort;
    assign frames_inc = (o_frames_sent == 16'hFFFF) ? o_frames_sent : o_frames_sent + 16'd1;

    // With a zero gap the stop decision is taken on the fall itself, so it uses the incremented count
    assign stop_at_fall = abort_now || ((num_frames != 16'd0) && (frames_inc == num_frames));
    assign stop_at_gap  = abort_now || ((num_frames != 16'd0) && (o_frames_sent == num_frames));

    always_ff @(posedge clk) begin
        if (i_rst) begin
            state            <= ST_IDLE;
            num_frames       <= '0;
            len_min          <= '0;
            len_max          <= '0;
            len_step         <= '0;
            cur_len          <= '0;
            gap_cycles       <= '0;
            gap_cnt          <= '0;
            pulse_cnt        <= '0;
            wdog_cnt         <= '0;
            abort_pend       <= 1'b0;
            o_start          <= 1'b0;
            o_payload_length <= '0;
            o_mode           <= '0;
            o_prbs_rst_n     <= 1'b0;
            o_busy           <= 1'b0;
            o_done           <= 1'b0;
            o_frames_sent    <= '0;
            o_wdog_err       <= 1'b0;
        end else begin
            if ((state != ST_IDLE) && i_abort) begin
                abort_pend <= 1'b1;
            end

            case (state)
                ST_IDLE: begin
                    if (i_go) begin
                        num_frames    <= i_num_frames;
                        len_min       <= i_len_min;
                        len_max       <= i_len_max;
                        len_step      <= i_len_step;
                        cur_len       <= i_len_min;
                        gap_cycles    <= i_gap_cycles;
                        o_mode        <= i_mode;
                        o_frames_sent <= '0;
                        o_wdog_err    <= 1'b0;
                        abort_pend    <= 1'b0;
                        o_prbs_rst_n  <= (i_mode != MODE_PRBS8);
                        o_busy        <= 1'b1;
                        state         <= ST_LAUNCH;
                    end
                end

                ST_LAUNCH: begin
                    o_prbs_rst_n     <= 1'b1;
                    o_payload_length <= clamp_len(cur_len, LEN_CAP);
                    o_busy           <= 1'b1;
                    o_start          <= 1'b1;
                    pulse_cnt        <= '0;
                    wdog_cnt         <= '0;
                    state            <= ST_START;
                end

                ST_START: begin
                    wdog_cnt <= wdog_cnt + 1'b1;
                    if (pulse_cnt == PULSE_LAST) begin
                        o_start <= 1'b0;
                        state   <= ST_WAIT_TX;
                    end else begin
                        pulse_cnt <= pulse_cnt + 1'b1;
                    end
                end

                ST_WAIT_TX: begin
                    if (i_tx_valid) begin
                        wdog_cnt <= '0;
                        state    <= ST_IN_TX;
                    end else if (wdog_cnt == WDOG_LAST) begin
                        o_wdog_err <= 1'b1;
                        o_start    <= 1'b0;
                        o_busy     <= 1'b0;
                        o_done     <= 1'b1;
                        state      <= ST_ERR;
                    end else begin
                        wdog_cnt <= wdog_cnt + 1'b1;
                    end
                end

                ST_IN_TX: begin
                    if (!i_tx_valid) begin
                        o_frames_sent <= frames_inc;
                        if (gap_cycles != '0) begin
                            gap_cnt <= '0;
                            state   <= ST_GAP;
                        end else if (stop_at_fall) begin
                            o_done <= 1'b1;
                            o_busy <= 1'b0;
                            state  <= ST_FINISH;
                        end else begin
                            cur_len <= next_len;
                            state   <= ST_LAUNCH;
                        end
                    end else if (wdog_cnt == WDOG_LAST) begin
                        o_wdog_err <= 1'b1;
                        o_start    <= 1'b0;
                        o_busy     <= 1'b0;
                        o_done     <= 1'b1;
                        state      <= ST_ERR;
                    end else begin
                        wdog_cnt <= wdog_cnt + 1'b1;
                    end
                end

                ST_GAP: begin
                    if (gap_cnt == gap_cycles - 1'b1) begin
                        if (stop_at_gap) begin
                            o_done <= 1'b1;
                            o_busy <= 1'b0;
                            state  <= ST_FINISH;
                        end else begin
                            cur_len <= next_len;
                            state   <= ST_LAUNCH;
                        end
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end

                ST_FINISH: begin
                    o_done <= 1'b0;
                    state  <= ST_IDLE;
                end

                ST_ERR: begin
                    o_done <= 1'b0;
                    state  <= ST_IDLE;
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mac_tx_scheduler.sv
// tb/tb_mac_tx_scheduler.sv - scoreboard bench for mac_tx_scheduler
module tb_mac_tx_scheduler;

    logic        clk;
    logic        i_rst;
    logic        i_go;
    logic        i_abort;
    logic [15:0] i_num_frames;
    logic [15:0] i_len_min;
    logic [15:0] i_len_max;
    logic [15:0] i_len_step;
    logic [7:0]  i_mode;
    logic [15:0] i_gap_cycles;
    logic        tx_valid;
    logic        o_start;
    logic [15:0] o_payload_length;
    logic [7:0]  o_mode;
    logic        o_prbs_rst_n;
    logic        o_busy;
    logic        o_done;
    logic [15:0] o_frames_sent;
    logic        o_wdog_err;

    typedef struct {
        int len;
        int delta;
    } start_exp_t;

    typedef struct {
        int frames;
        int wdog;
        int lat;
    } done_exp_t;

    start_exp_t exp_starts[$];
    done_exp_t  exp_dones[$];

    int n_vec  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int last_fall  = 0;
    int last_start = 0;
    bit stub_en    = 1'b1;

    mac_tx_scheduler dut (
        .clk             (clk),
        .i_rst           (i_rst),
        .i_go            (i_go),
        .i_abort         (i_abort),
        .i_num_frames    (i_num_frames),
        .i_len_min       (i_len_min),
        .i_len_max       (i_len_max),
        .i_len_step      (i_len_step),
        .i_mode          (i_mode),
        .i_gap_cycles    (i_gap_cycles),
        .i_tx_valid      (tx_valid),
        .o_start         (o_start),
        .o_payload_length(o_payload_length),
        .o_mode          (o_mode),
        .o_prbs_rst_n    (o_prbs_rst_n),
        .o_busy          (o_busy),
        .o_done          (o_done),
        .o_frames_sent   (o_frames_sent),
        .o_wdog_err      (o_wdog_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic bad(input string name);
        n_vec++;
        n_fail++;
        $display("FAIL %s: event seen with nothing expected (cycle %0d)", name, cyc);
    endtask

    // Stub generator: tx-valid rises 2 cycles after the start pulse and stays high 10 cycles
    initial begin
        tx_valid = 1'b0;
        forever begin
            @(negedge clk);
            if (stub_en && o_start) begin
                while (o_start) @(negedge clk);
                repeat (2) @(posedge clk);
                #1 tx_valid = 1'b1;
                repeat (10) @(posedge clk);
                #1 tx_valid = 1'b0;
            end
        end
    end

    // Monitor: pops the scoreboard whenever a start rises or done is presented
    initial begin
        bit prev_start = 1'b0;
        bit prev_tx    = 1'b0;
        int start_hi   = 0;
        start_exp_t se;
        done_exp_t  de;
        forever begin
            @(negedge clk);
            if (prev_tx && !tx_valid) last_fall = cyc;
            if (o_start && !prev_start) begin
                last_start = cyc;
                if (exp_starts.size() == 0) begin
                    bad("unexpected_start");
                end else begin
                    se = exp_starts.pop_front();
                    chk("start_len", int'(o_payload_length), se.len);
                    if (se.delta >= 0) chk("gap_delta", cyc - last_fall, se.delta);
                end
            end
            if (o_start) begin
                start_hi++;
            end else if (prev_start) begin
                chk("start_width", start_hi, 2);
                start_hi = 0;
            end
            if (o_done) begin
                if (exp_dones.size() == 0) begin
                    bad("unexpected_done");
                end else begin
                    de = exp_dones.pop_front();
                    chk("done_frames", int'(o_frames_sent), de.frames);
                    chk("done_wdog", int'(o_wdog_err), de.wdog);
                    chk("done_busy", int'(o_busy), 0);
                    if (de.lat >= 0) chk("wdog_latency", cyc - last_start, de.lat);
                end
            end
            prev_start = o_start;
            prev_tx    = tx_valid;
        end
    end

    task automatic start_burst(input int nf, input int lmin, input int lmax, input int lstep,
                               input int mode, input int gap);
        @(posedge clk);
        #1;
        i_num_frames = 16'(nf);
        i_len_min    = 16'(lmin);
        i_len_max    = 16'(lmax);
        i_len_step   = 16'(lstep);
        i_mode       = 8'(mode);
        i_gap_cycles = 16'(gap);
        i_go         = 1'b1;
        @(posedge clk);
        #1 i_go = 1'b0;
    endtask

    task automatic wait_done(input string name, input int maxc);
        int c = 0;
        do begin
            @(negedge clk);
            c++;
        end while (!o_done && c < maxc);
        chk(name, int'(o_done), 1);
        repeat (3) @(negedge clk);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_start"}, int'(o_start), 0);
        chk({tag, "_len"}, int'(o_payload_length), 0);
        chk({tag, "_mode"}, int'(o_mode), 0);
        chk({tag, "_prbs"}, int'(o_prbs_rst_n), 0);
        chk({tag, "_busy"}, int'(o_busy), 0);
        chk({tag, "_done"}, int'(o_done), 0);
        chk({tag, "_frames"}, int'(o_frames_sent), 0);
        chk({tag, "_wdog"}, int'(o_wdog_err), 0);
    endtask

    initial begin
        int c;
        i_rst = 1'b1; i_go = 1'b0; i_abort = 1'b0;
        i_num_frames = '0; i_len_min = '0; i_len_max = '0; i_len_step = '0;
        i_mode = '0; i_gap_cycles = '0;
        repeat (3) @(posedge clk);
        #1 i_rst = 1'b0;
        @(negedge clk);
        check_reset_vals("rst");

        // Fixed 64-byte burst of 3, gap 12: next start 14 cycles after the first low tx-valid cycle
        exp_starts.push_back('{64, -1});
        exp_starts.push_back('{64, 14});
        exp_starts.push_back('{64, 14});
        exp_dones.push_back('{3, 0, -1});
        start_burst(3, 64, 64, 0, 0, 12);
        i_len_min = 16'd999; i_num_frames = 16'd7; i_gap_cycles = 16'd1;
        wait_done("t1_done", 500);
        chk("t1_busy_after", int'(o_busy), 0);
        chk("t1_len_hold", int'(o_payload_length), 64);

        // Sweep 46..64 step 8 wraps after 62
        exp_starts.push_back('{46, -1});
        exp_starts.push_back('{54, 5});
        exp_starts.push_back('{62, 5});
        exp_starts.push_back('{46, 5});
        exp_dones.push_back('{4, 0, -1});
        start_burst(4, 46, 64, 8, 0, 3);
        wait_done("t2_done", 500);

        // 1490 + 20 exceeds the 1500 cap, so every frame is 1490; zero gap
        exp_starts.push_back('{1490, -1});
        exp_starts.push_back('{1490, 2});
        exp_starts.push_back('{1490, 2});
        exp_dones.push_back('{3, 0, -1});
        start_burst(3, 1490, 2000, 20, 0, 0);
        wait_done("t3_done", 500);

        // Continuous PRBS burst stopped by abort during the third frame
        chk("t4_prbs_pre", int'(o_prbs_rst_n), 1);
        exp_starts.push_back('{100, -1});
        exp_starts.push_back('{110, 4});
        exp_starts.push_back('{120, 4});
        exp_dones.push_back('{3, 0, -1});
        start_burst(0, 100, 120, 10, 3, 2);
        @(negedge clk);
        chk("t4_prbs_low", int'(o_prbs_rst_n), 0);
        chk("t4_mode", int'(o_mode), 3);
        chk("t4_busy", int'(o_busy), 1);
        @(negedge clk);
        chk("t4_prbs_high", int'(o_prbs_rst_n), 1);
        c = 0;
        while (o_frames_sent != 16'd2 && c < 300) begin @(negedge clk); c++; end
        chk("t4_two_sent", int'(o_frames_sent), 2);
        c = 0;
        while (!tx_valid && c < 50) begin @(negedge clk); c++; end
        chk("t4_third_tx", int'(tx_valid), 1);
        @(posedge clk); #1 i_abort = 1'b1;
        @(posedge clk); #1 i_abort = 1'b0;
        wait_done("t4_done", 200);
        repeat (40) @(negedge clk);

        // Generator never answers: watchdog fires 4096 cycles after the start pulse begins
        stub_en = 1'b0;
        exp_starts.push_back('{64, -1});
        exp_dones.push_back('{0, 1, 4096});
        start_burst(1, 64, 64, 0, 0, 0);
        wait_done("t5_done", 5000);
        chk("t5_wdog_sticky", int'(o_wdog_err), 1);
        stub_en = 1'b1;
        exp_starts.push_back('{64, -1});
        exp_dones.push_back('{1, 0, -1});
        start_burst(1, 64, 64, 0, 0, 0);
        @(negedge clk);
        chk("t5_wdog_clear", int'(o_wdog_err), 0);
        wait_done("t5b_done", 200);

        // Reset landing in the second start cycle
        stub_en = 1'b0;
        exp_starts.push_back('{64, -1});
        start_burst(1, 64, 64, 0, 0, 0);
        c = 0;
        while (!o_start && c < 10) begin @(negedge clk); c++; end
        chk("t6_in_start", int'(o_start), 1);
        @(posedge clk); #1 i_rst = 1'b1;
        @(posedge clk); #1;
        check_reset_vals("t6");
        i_rst = 1'b0;
        repeat (10) @(negedge clk);
        chk("t6_idle_start", int'(o_start), 0);
        chk("t6_idle_busy", int'(o_busy), 0);

        chk("starts_left", exp_starts.size(), 0);
        chk("dones_left", exp_dones.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/mac_tx_scheduler.md
Name: mac_tx_scheduler

Overview:
Sequencer for the MAC frame generator / MII generator pair (mac_mii_top). It accepts a burst program (frame count, payload-length sweep, mode, inter-frame gap) and issues start pulses. It tracks each frame's transmit-valid window and enforces the gap between frames. It also flags generator stalls through a watchdog. It sits between the test-control/register side and mac_mii_top, and replaces hand-driven start/length sequencing.

Parameters:
PAYLOAD_MAX_SIZE, 1500, largest legal payload length in bytes; all lengths clamp to this
START_PULSE_CYCLES, 2, width of o_start pulse in clk cycles
GAP_WIDTH, 16, width of inter-frame gap counter
WDOG_CYCLES, 4096, max cycles allowed from start to rising edge of tx-valid, and for tx-valid high

Ports:
clk  in  1  system clock
i_rst  in  1  synchronous reset, active-high
i_go  in  1  one-cycle request to launch a burst; honoured only in IDLE
i_abort  in  1  stop after current frame completes; no further starts
i_num_frames  in  16  frames in burst; 0 = run until abort
i_len_min  in  16  first payload length
i_len_max  in  16  sweep upper bound
i_len_step  in  16  length increment per frame; 0 = fixed length
i_mode  in  8  generator mode (0 normal, 1 fixed, 2 no-pad, 3 PRBS8)
i_gap_cycles  in  GAP_WIDTH  idle cycles after tx-valid falls before next start
i_tx_valid  in  1  generator o_txValid
o_start  out  1  start pulse to generator
o_payload_length  out  16  payload length to generator, stable from start to tx-valid fall
o_mode  out  8  mode to generator, latched per burst
o_prbs_rst_n  out  1  PRBS reset to generator, low for 1 cycle at burst launch when mode==3
o_busy  out  1  burst in progress
o_done  out  1  one-cycle pulse when burst ends normally or by abort
o_frames_sent  out  16  frames completed in current/last burst
o_wdog_err  out  1  sticky watchdog error; cleared by i_go or i_rst

Behaviour:
- Reset values: o_start=0, o_payload_length=0, o_mode=0, o_prbs_rst_n=0, o_busy=0, o_done=0, o_frames_sent=0, o_wdog_err=0; state IDLE.
- FSM states: IDLE, LAUNCH, START, WAIT_TX, IN_TX, GAP, FINISH, ERR.
- IDLE: on i_go, latch all i_* config. Clear o_frames_sent and o_wdog_err. Set o_prbs_rst_n=0 for that cycle, then 1 thereafter. Go to LAUNCH. The following inputs are ignored after latching: i_go, i_num_frames, i_len_min, i_len_max, i_len_step, i_mode, i_gap_cycles.
- LAUNCH (1 cycle): o_payload_length = min(cur_len, PAYLOAD_MAX_SIZE); o_busy=1; go to START.
- START: o_start=1 for exactly START_PULSE_CYCLES cycles; o_payload_length is already valid in the first start cycle. Then go to WAIT_TX.
- WAIT_TX: wait for i_tx_valid=1, then go to IN_TX. If WDOG_CYCLES elapse since entering START, go to ERR.
- IN_TX: on i_tx_valid falling, increment o_frames_sent and go to GAP. If tx-valid stays high WDOG_CYCLES, go to ERR.
- GAP: count i_gap_cycles idle cycles; gap 0 means next LAUNCH immediately on the cycle after the fall. At end of gap:
  - go to FINISH if abort is pending, or if i_num_frames!=0 and o_frames_sent==i_num_frames;
  - otherwise advance length and go to LAUNCH.
- Length advance: next = cur_len + i_len_step in 17-bit arithmetic. If next > i_len_max or next > PAYLOAD_MAX_SIZE, wrap to i_len_min. If i_len_min > i_len_max, the length is fixed at min(i_len_min, PAYLOAD_MAX_SIZE).
- i_abort: latched to a pending flag in any non-IDLE state. It never truncates an in-flight frame. If asserted in LAUNCH or START, that frame still completes. Ignored in IDLE.
- FINISH (1 cycle): o_done=1, o_busy=0, go to IDLE.
- ERR: o_wdog_err=1 (sticky), o_start=0, o_busy=0, pulse o_done; go to IDLE.
- o_frames_sent saturates at 16'hFFFF in continuous mode; it does not wrap.
- i_go and i_abort in the same IDLE cycle: launch proceeds, abort is ignored.
- i_rst in any state: return to reset values within the same edge. o_start drops immediately, even mid-pulse.

Decomposition:
- Shared package mac_tb_pkg:
  - FSM state enum;
  - mode constants MODE_NORMAL=0, MODE_FIXED=1, MODE_NOPAD=2, MODE_PRBS8=3;
  - PAYLOAD_MAX_SIZE default.
- One sub-module, sched_len_sweep: combinational next-length computation with clamp and wrap.
- Counters (pulse, gap, watchdog) stay inline.

Test Plan:
- i_go with num_frames=3, len_min=len_max=64, step=0, gap=12, mode=0 -> exactly 3 two-cycle o_start pulses, each 12 idle cycles after tx-valid fall; o_payload_length=64 throughout; o_frames_sent=3; one o_done pulse; o_busy low after.
- Sweep len_min=46, len_max=64, step=8, num_frames=4 -> lengths 46,54,62,46.
- len_min=1490, step=20, len_max=2000 -> lengths 1490 then 1490 again (1510 exceeds 1500, so it wraps); never exceeds 1500.
- num_frames=0, mode=3 -> o_prbs_rst_n low 1 cycle at launch; frames continue until i_abort is pulsed mid-frame; that frame completes; o_done follows; no further o_start.
- Stub generator never raises tx-valid -> o_wdog_err=1 after 4096 cycles, o_done pulse; next i_go clears o_wdog_err.
- i_rst asserted during second START cycle -> o_start=0 on the next edge; all outputs at reset values; state IDLE.
